// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: MIPS front-end sequencer for branch flush, memory freeze and load-use stall.
// Define HAZARD_PERF_CNT_EN to build the stall_cycles/flush_cycles performance counters.
module hazard_flush_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_WAIT     = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  br_taken,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  stall_active,
  output logic                  wait_timeout,
  output logic [1:0]            state_o,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           flush_cycles
);
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2, LU_STALL = 2'd3} state_t;
  localparam logic [2:0] FLOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WMAX  = 8'(MAX_WAIT);
  state_t     state, state_nx;
  logic [2:0] fcnt, fcnt_nx;
  logic [7:0] wcnt, wcnt_nx;
  logic       lu, in_flush, hold, eval, evt_br, evt_mem, evt_lu, reload;
  logic       pc_en, flush_en, bubble_en;
  assign lu = ex_mem_read & (ex_rt != '0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign in_flush = state == FLUSH;
  assign hold     = (state == MEM_WAIT) & mem_busy;
  // The release cycle of a freeze evaluates events like RUN so a held branch/load is not lost.
  assign eval     = (state == RUN) | (state == LU_STALL) | ((state == MEM_WAIT) & ~mem_busy);
  assign evt_br   = eval & br_taken;
  assign evt_mem  = eval & ~br_taken & mem_busy;
  assign evt_lu   = eval & (state != LU_STALL) & ~br_taken & ~mem_busy & lu;
  assign reload   = br_taken & (in_flush | eval);
  assign flush_en  = in_flush | evt_br;
  assign pc_en     = ~(hold | evt_mem | evt_lu);
  assign bubble_en = flush_en | evt_lu;
  assign pc_write     = ~reset & pc_en;
  assign if_id_write  = ~reset & pc_en;
  assign if_id_flush  = reset | flush_en;
  assign id_ex_bubble = reset | bubble_en;
  assign stall_active = ~pc_write;
  assign state_o      = state;
  always_comb begin
    fcnt_nx  = reload ? FLOAD : in_flush ? fcnt - 3'd1 : fcnt;
    wcnt_nx  = evt_mem ? 8'd1 : hold ? ((wcnt == 8'hFF) ? wcnt : wcnt + 8'd1) : 8'd0;
    state_nx = reload ? ((FLOAD != 3'd0) ? FLUSH : RUN) :
               in_flush ? ((fcnt <= 3'd1) ? RUN : FLUSH) :
               (hold | evt_mem) ? MEM_WAIT :
               evt_lu ? LU_STALL : RUN;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      fcnt         <= '0;
      wcnt         <= '0;
      wait_timeout <= 1'b0;
    end else begin
      state        <= state_nx;
      fcnt         <= fcnt_nx;
      wcnt         <= wcnt_nx;
      wait_timeout <= wait_timeout | ((hold | evt_mem) & (wcnt_nx == WMAX));
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (~pc_en & (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
      if (flush_en & (flush_cycles != 16'hFFFF)) flush_cycles <= flush_cycles + 16'd1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif
endmodule
